// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: walks the 16 state bytes through LANES external S-box ROMs,
// substituting in place, with valid/ready handshakes on both sides.

module sub_bytes_lane #(
   parameter int STEPS = 16,
   parameter int CW    = 4
) (
   input  logic                   en,
   input  logic [CW-1:0]          step,
   input  logic [STEPS-1:0][7:0]  cand,
   output logic [7:0]             addr
);
   assign addr = en ? cand[step] : 8'h00;
endmodule

module sub_bytes_seq #(
   parameter int LANES = 1
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 v_i,
   output logic                 ready_o,
   input  logic [127:0]         state_i,
   output logic                 v_o,
   input  logic                 ready_i,
   output logic [127:0]         state_o,
   output logic [8*LANES-1:0]   sbox_addr_o,
   input  logic [8*LANES-1:0]   sbox_data_i
);
   localparam int STEPS = 16 / LANES;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
         $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            st_q;
   logic [CW-1:0]     step_q;
   logic [15:0][7:0]  data_q;   // byte k lives at index 15-k
   logic [15:0][7:0]  sub_buf;
   logic              busy;

   assign busy    = (st_q == BUSY);
   assign ready_o = (st_q == IDLE) || ((st_q == DONE) && ready_i);
   assign state_o = data_q;

   // Lane j at step s addresses byte s*LANES+j.
   generate
      for (genvar j = 0; j < LANES; j++) begin : g_lane
         logic [STEPS-1:0][7:0] cand;
         for (genvar s = 0; s < STEPS; s++) begin : g_cand
            assign cand[s] = data_q[15-(s*LANES+j)];
         end
         sub_bytes_lane #(.STEPS(STEPS), .CW(CW)) u_lane (
            .en   (busy),
            .step (step_q),
            .cand (cand),
            .addr (sbox_addr_o[8*j +: 8])
         );
      end

      for (genvar k = 0; k < 16; k++) begin : g_sub
         assign sub_buf[15-k] = (step_q == CW'(k / LANES)) ? sbox_data_i[8*(k % LANES) +: 8]
                                                          : data_q[15-k];
      end
   endgenerate

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         st_q   <= IDLE;
         step_q <= '0;
         data_q <= '0;
         v_o    <= 1'b0;
      end else begin
         case (st_q)
            IDLE: begin
               if (v_i) begin
                  data_q <= state_i;
                  step_q <= '0;
                  st_q   <= BUSY;
               end
            end
            BUSY: begin
               data_q <= sub_buf;
               if (step_q == CW'(STEPS - 1)) begin
                  st_q <= DONE;
                  v_o  <= 1'b1;
               end else begin
                  step_q <= step_q + 1'b1;
               end
            end
            DONE: begin
               // Pop and push may coincide for back-to-back blocks.
               if (ready_i) begin
                  v_o <= 1'b0;
                  if (v_i) begin
                     data_q <= state_i;
                     step_q <= '0;
                     st_q   <= BUSY;
                  end else begin
                     st_q <= IDLE;
                  end
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end
endmodule
